// File: rtl/axis_fifo_scheduler_pkg.sv
// Shared types and constants for the AXI-Stream FIFO scheduler.
package axis_sched_pkg;

    // Scheduler states: wait for a request, move one packet, one dead cycle.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_GAP  = 2'd2
    } sched_state_e;

    // bus_sel code meaning "no FIFO connected".
    localparam logic [7:0] SEL_NONE         = 8'd0;
    // Default offset added to the FIFO index to form the bus_sel code.
    localparam logic [7:0] SEL_BASE_DEFAULT = 8'd128;
    // Width of the saturating per-packet beat counter.
    localparam int         BEAT_CNT_W       = 16;
    // Width of a FIFO index (enough for up to 16 FIFOs).
    localparam int         GRANT_W          = 4;

endpackage

// File: rtl/axis_fifo_scheduler_if.sv
// Muxed stream handshake as seen downstream, plus the select code back to the mux.
//
// Handshake: a beat transfers on a rising clk edge where axis_in_tvalid and
// axis_in_tready are both high; axis_in_tlast qualifies that beat as the last
// one of the packet. bus_sel is driven by the scheduler only.
interface axis_fifo_scheduler_if;
    logic       axis_in_tvalid;
    logic       axis_in_tready;
    logic       axis_in_tlast;
    logic [7:0] bus_sel;

    // Stream side: owns the handshake, observes the select code.
    modport master (
        output axis_in_tvalid,
        output axis_in_tready,
        output axis_in_tlast,
        input  bus_sel
    );

    // Scheduler side: observes the handshake, drives the select code.
    modport slave (
        input  axis_in_tvalid,
        input  axis_in_tready,
        input  axis_in_tlast,
        output bus_sel
    );
endinterface

// File: rtl/axis_fifo_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first requester searching upward from
// last_grant+1, wrapping modulo NUM_FIFO.
module rr_arbiter
    import axis_sched_pkg::*;
#(
    parameter int NUM_FIFO = 12
) (
    input  logic [NUM_FIFO-1:0] req_i,
    input  logic [GRANT_W-1:0]  last_grant_i,
    output logic [GRANT_W-1:0]  grant_o,
    output logic                found_o
);

    // Widen the request vector so a GRANT_W-bit index always fits.
    logic [(1<<GRANT_W)-1:0] req_ext;
    assign req_ext = (1 << GRANT_W)'(req_i);

    // Scan NUM_FIFO positions starting just after the previous winner.
    always_comb begin
        logic [GRANT_W-1:0] idx;
        grant_o = '0;
        found_o = 1'b0;
        idx     = '0;
        for (int i = 1; i <= NUM_FIFO; i++) begin
            idx = GRANT_W'((int'(last_grant_i) + i) % NUM_FIFO);
            if (!found_o && req_ext[idx]) begin
                grant_o = idx;
                found_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/axis_fifo_scheduler.sv
// Packet scheduler: grants one upstream FIFO at a time onto a shared
// AXI-Stream path, round-robin, with a per-packet stall timeout.
module axis_fifo_scheduler
    import axis_sched_pkg::*;
#(
    parameter int         NUM_FIFO       = 12,
    parameter logic [7:0] SEL_BASE       = SEL_BASE_DEFAULT,
    parameter int         TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic [NUM_FIFO-1:0]   fifo_req,
    axis_fifo_scheduler_if.slave  axis,
    output logic [GRANT_W-1:0]    cur_grant,
    output logic                  busy,
    output logic                  pkt_done,
    output logic                  timeout_err,
    output logic [BEAT_CNT_W-1:0] beat_cnt,
    output logic [1:0]            dbg_state
);

    localparam logic [1:0] S_IDLE = ST_IDLE;
    localparam logic [1:0] S_XFER = ST_XFER;
    localparam logic [1:0] S_GAP  = ST_GAP;

    localparam int STALL_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [STALL_W-1:0] STALL_LIMIT = STALL_W'(TIMEOUT_CYCLES - 1);

    logic [1:0]            state_q,       state_d;
    logic [7:0]            bus_sel_q,     bus_sel_d;
    logic [GRANT_W-1:0]    cur_grant_q,   cur_grant_d;
    logic [GRANT_W-1:0]    last_grant_q,  last_grant_d;
    logic [BEAT_CNT_W-1:0] beat_cnt_q,    beat_cnt_d;
    logic [STALL_W-1:0]    stall_q,       stall_d;
    logic                  pkt_done_q,    pkt_done_d;
    logic                  timeout_q,     timeout_d;

    logic [GRANT_W-1:0]    arb_grant;
    logic                  arb_found;
    logic                  beat;

    rr_arbiter #(.NUM_FIFO(NUM_FIFO)) u_arb (
        .req_i        (fifo_req),
        .last_grant_i (last_grant_q),
        .grant_o      (arb_grant),
        .found_o      (arb_found)
    );

    assign beat = (state_q == S_XFER) && axis.axis_in_tvalid && axis.axis_in_tready;

    // Next-state logic: grant in IDLE, count beats and stalls in XFER, one GAP cycle.
    always_comb begin
        state_d      = state_q;
        bus_sel_d    = bus_sel_q;
        cur_grant_d  = cur_grant_q;
        last_grant_d = last_grant_q;
        beat_cnt_d   = beat_cnt_q;
        stall_d      = stall_q;
        pkt_done_d   = 1'b0;
        timeout_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                bus_sel_d = SEL_NONE;
                if (enable && arb_found) begin
                    state_d     = S_XFER;
                    cur_grant_d = arb_grant;
                    beat_cnt_d  = '0;
                    stall_d     = '0;
                    bus_sel_d   = SEL_BASE + 8'(arb_grant);
                end
            end
            S_XFER: begin
                // A beat always wins over a timeout landing in the same cycle.
                if (beat) begin
                    stall_d = '0;
                    if (beat_cnt_q != '1) begin
                        beat_cnt_d = beat_cnt_q + 1'b1;
                    end
                    if (axis.axis_in_tlast) begin
                        pkt_done_d   = 1'b1;
                        last_grant_d = cur_grant_q;
                        state_d      = S_GAP;
                        bus_sel_d    = SEL_NONE;
                    end
                end else if (stall_q == STALL_LIMIT) begin
                    timeout_d    = 1'b1;
                    last_grant_d = cur_grant_q;
                    state_d      = S_GAP;
                    bus_sel_d    = SEL_NONE;
                end else begin
                    stall_d = stall_q + 1'b1;
                end
            end
            S_GAP: begin
                state_d   = S_IDLE;
                bus_sel_d = SEL_NONE;
            end
            default: begin
                state_d   = S_IDLE;
                bus_sel_d = SEL_NONE;
            end
        endcase
    end

    // State registers; reset abandons any packet in flight without a done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            bus_sel_q    <= SEL_NONE;
            cur_grant_q  <= '0;
            last_grant_q <= GRANT_W'(NUM_FIFO - 1);
            beat_cnt_q   <= '0;
            stall_q      <= '0;
            pkt_done_q   <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            bus_sel_q    <= bus_sel_d;
            cur_grant_q  <= cur_grant_d;
            last_grant_q <= last_grant_d;
            beat_cnt_q   <= beat_cnt_d;
            stall_q      <= stall_d;
            pkt_done_q   <= pkt_done_d;
            timeout_q    <= timeout_d;
        end
    end

    assign axis.bus_sel = bus_sel_q;
    assign cur_grant    = cur_grant_q;
    assign busy         = (state_q == S_XFER);
    assign pkt_done     = pkt_done_q;
    assign timeout_err  = timeout_q;
    assign beat_cnt     = beat_cnt_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_axis_fifo_scheduler.sv
// Directed bench for axis_fifo_scheduler: single packet, round-robin order,
// starvation guard, stall timeout, enable drop and mid-packet reset.
module tb_axis_fifo_scheduler;

    logic        clk;
    logic        rst;
    logic        enable;
    logic [11:0] fifo_req;
    logic [3:0]  cur_grant;
    logic        busy;
    logic        pkt_done;
    logic        timeout_err;
    logic [15:0] beat_cnt;
    logic [1:0]  dbg_state;

    int n_cmp = 0;
    int n_err = 0;

    axis_fifo_scheduler_if axis_if ();

    axis_fifo_scheduler #(
        .NUM_FIFO       (12),
        .SEL_BASE       (8'd128),
        .TIMEOUT_CYCLES (1024)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .fifo_req    (fifo_req),
        .axis        (axis_if),
        .cur_grant   (cur_grant),
        .busy        (busy),
        .pkt_done    (pkt_done),
        .timeout_err (timeout_err),
        .beat_cnt    (beat_cnt),
        .dbg_state   (dbg_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst                    = 1'b1;
        enable                 = 1'b0;
        fifo_req               = '0;
        axis_if.axis_in_tvalid = 1'b0;
        axis_if.axis_in_tready = 1'b1;
        axis_if.axis_in_tlast  = 1'b0;
        repeat (3) step();
        rst = 1'b0;
    endtask

    // Wait (bounded) for a grant, then check index and select code.
    task automatic wait_grant(input string tag, input int exp_grant);
        int n;
        n = 0;
        while (!busy && n < 8) begin
            step();
            n++;
        end
        check({tag, "_busy"},  32'(busy), 32'd1);
        check({tag, "_grant"}, 32'(cur_grant), 32'(exp_grant));
        check({tag, "_sel"},   32'(axis_if.bus_sel), 32'(128 + exp_grant));
    endtask

    // Drive n back-to-back beats, tlast on the final one.
    task automatic send_beats(input string tag, input int n, input int exp_sel);
        for (int i = 0; i < n; i++) begin
            axis_if.axis_in_tvalid = 1'b1;
            axis_if.axis_in_tlast  = (i == n - 1);
            check({tag, "_sel_xfer"}, 32'(axis_if.bus_sel), 32'(exp_sel));
            step();
        end
        axis_if.axis_in_tvalid = 1'b0;
        axis_if.axis_in_tlast  = 1'b0;
    endtask

    // Full packet: grant, beats, then GAP with done pulse and idle select.
    task automatic run_packet(input string tag, input int beats, input int exp_grant);
        wait_grant(tag, exp_grant);
        send_beats(tag, beats, 128 + exp_grant);
        check({tag, "_done"},  32'(pkt_done), 32'd1);
        check({tag, "_gapsel"}, 32'(axis_if.bus_sel), 32'd0);
        check({tag, "_gapst"}, 32'(dbg_state), 32'd2);
        check({tag, "_beats"}, 32'(beat_cnt), 32'(beats));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic seen_to;

        // Reset values
        do_reset();
        check("rst_sel",   32'(axis_if.bus_sel), 32'd0);
        check("rst_grant", 32'(cur_grant), 32'd0);
        check("rst_busy",  32'(busy), 32'd0);
        check("rst_done",  32'(pkt_done), 32'd0);
        check("rst_to",    32'(timeout_err), 32'd0);
        check("rst_beats", 32'(beat_cnt), 32'd0);
        check("rst_state", 32'(dbg_state), 32'd0);

        // Single 4-beat packet on FIFO 0, with one tvalid-without-tready cycle first
        fifo_req               = 12'h001;
        enable                 = 1'b1;
        axis_if.axis_in_tready = 1'b0;
        axis_if.axis_in_tvalid = 1'b1;
        wait_grant("single", 0);
        step();
        check("single_noready", 32'(beat_cnt), 32'd0);
        axis_if.axis_in_tready = 1'b1;
        fifo_req               = 12'h000;
        send_beats("single", 4, 128);
        check("single_done",   32'(pkt_done), 32'd1);
        check("single_beats",  32'(beat_cnt), 32'd4);
        check("single_gapsel", 32'(axis_if.bus_sel), 32'd0);
        step();
        check("single_done_1cyc", 32'(pkt_done), 32'd0);
        check("single_idle",      32'(dbg_state), 32'd0);
        check("single_hold",      32'(beat_cnt), 32'd4);
        check("single_idlesel",   32'(axis_if.bus_sel), 32'd0);

        // Round-robin over all twelve FIFOs and wrap back to 0
        do_reset();
        enable   = 1'b1;
        fifo_req = 12'hFFF;
        for (int i = 0; i < 12; i++) begin
            run_packet($sformatf("rr%0d", i), 1, i);
        end
        run_packet("rr_wrap", 1, 0);

        // Starvation guard: last grant 0, requests {3,0} -> 3 then 0
        fifo_req = 12'h009;
        run_packet("starve_a", 1, 3);
        run_packet("starve_b", 2, 0);
        fifo_req = 12'h000;
        step();

        // Stall timeout on FIFO 5
        fifo_req = 12'h020;
        wait_grant("to", 5);
        fifo_req = 12'h000;
        seen_to  = 1'b0;
        for (int k = 0; k < 1023; k++) begin
            step();
            seen_to = seen_to | timeout_err;
        end
        check("to_early",    32'(seen_to), 32'd0);
        check("to_stillbusy", 32'(busy), 32'd1);
        step();
        check("to_pulse",  32'(timeout_err), 32'd1);
        check("to_gap",    32'(dbg_state), 32'd2);
        check("to_gapsel", 32'(axis_if.bus_sel), 32'd0);
        check("to_nodone", 32'(pkt_done), 32'd0);
        step();
        check("to_pulse_1cyc", 32'(timeout_err), 32'd0);
        check("to_idle",       32'(dbg_state), 32'd0);

        // Enable drop mid-packet on FIFO 2 (last grant 5, so 2 is the only requester)
        fifo_req = 12'h004;
        wait_grant("en", 2);
        axis_if.axis_in_tvalid = 1'b1;
        axis_if.axis_in_tlast  = 1'b0;
        step();
        enable = 1'b0;
        check("en_keep_busy", 32'(busy), 32'd1);
        step();
        axis_if.axis_in_tlast = 1'b1;
        step();
        axis_if.axis_in_tvalid = 1'b0;
        axis_if.axis_in_tlast  = 1'b0;
        check("en_done",  32'(pkt_done), 32'd1);
        check("en_beats", 32'(beat_cnt), 32'd3);
        fifo_req = 12'hFFF;
        for (int k = 0; k < 6; k++) begin
            step();
            check($sformatf("en_nogrant%0d", k), 32'(axis_if.bus_sel), 32'd0);
        end
        check("en_notbusy", 32'(busy), 32'd0);

        // Reset on beat 2 of FIFO 7 (last grant 2)
        enable   = 1'b1;
        fifo_req = 12'h080;
        wait_grant("rm", 7);
        axis_if.axis_in_tvalid = 1'b1;
        axis_if.axis_in_tlast  = 1'b0;
        step();
        check("rm_beat1", 32'(beat_cnt), 32'd1);
        rst = 1'b1;
        step();
        rst                    = 1'b0;
        axis_if.axis_in_tvalid = 1'b0;
        check("rm_sel",    32'(axis_if.bus_sel), 32'd0);
        check("rm_nodone", 32'(pkt_done), 32'd0);
        check("rm_busy",   32'(busy), 32'd0);
        check("rm_beats",  32'(beat_cnt), 32'd0);
        fifo_req = 12'h081;
        wait_grant("rm_next", 0);
        fifo_req               = 12'h000;
        axis_if.axis_in_tvalid = 1'b1;
        axis_if.axis_in_tlast  = 1'b1;
        step();
        axis_if.axis_in_tvalid = 1'b0;
        axis_if.axis_in_tlast  = 1'b0;
        check("rm_next_done", 32'(pkt_done), 32'd1);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/axis_fifo_scheduler.md
AXIS_FIFO_SCHEDULER -- requirements
Module: axis_fifo_scheduler

Interface
REQ-001 The block SHALL have parameter NUM_FIFO, default 12, giving the number of upstream FIFOs (1..12).
REQ-002 The block SHALL have parameter SEL_BASE, default 8'd128, the bus_sel code offset, so FIFO n is selected by SEL_BASE+n.
REQ-003 The block SHALL have parameter TIMEOUT_CYCLES, default 1024, the maximum stall cycles allowed inside a packet.
REQ-004 The block SHALL have one clock and a synchronous, active-high reset, named clk and rst.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: synchronous active-high reset.
REQ-007 The block SHALL have port enable, input, 1 bit: permits new grants.
REQ-008 The block SHALL have port fifo_req, input, NUM_FIFO bits: bit n high means FIFO n holds at least one beat.
REQ-009 The block SHALL have ports axis_in_tvalid, axis_in_tready and axis_in_tlast, inputs, 1 bit each: the muxed stream handshake as seen at the downstream side.
REQ-010 The block SHALL have port bus_sel, output, 8 bits: the select code to the demux/mux pair; 8'd0 means no FIFO.
REQ-011 The block SHALL have port cur_grant, output, 4 bits: index of the granted FIFO, valid while busy.
REQ-012 The block SHALL have port busy, output, 1 bit: high in XFER.
REQ-013 The block SHALL have port pkt_done, output, 1 bit: one-cycle pulse on tlast handshake.
REQ-014 The block SHALL have port timeout_err, output, 1 bit: one-cycle pulse on stall timeout.
REQ-015 The block SHALL have port beat_cnt, output, 16 bits: beats of the current or last packet, saturating at 16'hFFFF.

Function
REQ-016 The block SHALL implement the states IDLE, XFER and GAP.
REQ-017 In IDLE, bus_sel SHALL be 0; if enable is high and fifo_req is nonzero, the block SHALL grant a FIFO, load cur_grant, clear beat_cnt and enter XFER on the next edge.
REQ-018 Grant selection SHALL be round-robin: the first requesting index searching upward from last_grant+1 modulo NUM_FIFO; last_grant resets to NUM_FIFO-1, so index 0 wins first.
REQ-019 In XFER, bus_sel SHALL equal SEL_BASE+cur_grant, registered with no combinational path from inputs.
REQ-020 A beat SHALL be counted when axis_in_tvalid and axis_in_tready are both high in XFER.
REQ-021 On a beat with axis_in_tlast high, the block SHALL pulse pkt_done, update last_grant to cur_grant and enter GAP.
REQ-022 GAP SHALL last exactly one cycle with bus_sel 0, then return to IDLE, giving a grant-to-grant minimum of 2 idle-select cycles.
REQ-023 A stall counter SHALL clear on every beat and increment on every non-beat XFER cycle.
REQ-024 When the stall counter reaches TIMEOUT_CYCLES-1 without a beat, the block SHALL pulse timeout_err, update last_grant and enter GAP.
REQ-025 A beat and a timeout in the same cycle SHALL be resolved in favour of the beat.
REQ-026 Deasserting enable SHALL NOT preempt XFER; the current packet completes and no new grant follows.
REQ-027 fifo_req changes during XFER SHALL be ignored.
REQ-028 fifo_req bits at or above NUM_FIFO SHALL be ignored.
REQ-029 beat_cnt SHALL hold its value through GAP and IDLE until the next grant.

Reset
REQ-030 On rst, the block SHALL enter IDLE and set bus_sel=0, cur_grant=0, busy=0, pkt_done=0, timeout_err=0, beat_cnt=0, stall counter=0 and last_grant=NUM_FIFO-1.
REQ-031 Reset mid-packet SHALL abandon the packet with no pkt_done pulse.

Structure
REQ-032 Package axis_sched_pkg SHALL hold the state enum, SEL_NONE=8'd0, the SEL_BASE default and the beat counter width.
REQ-033 The block SHALL contain one combinational sub-module, rr_arbiter, which takes the request vector and last_grant and returns the grant index and a found flag.

Verification
REQ-034 Directed test, single packet: after reset, fifo_req=12'h001 and enable=1, then a 4-beat packet with tlast on beat 4 -> bus_sel=128 for 4+ cycles, pkt_done pulse, beat_cnt=4, bus_sel=0 in GAP.
REQ-035 Directed test, round-robin: fifo_req=12'hFFF held, 1-beat packets -> grant order 0,1,2,...,11,0 and bus_sel sequence 128..139,128.
REQ-036 Directed test, starvation guard: fifo_req=12'h009, last_grant=0 -> next grant is 3, then 0.
REQ-037 Directed test, timeout: grant FIFO 5, hold tvalid=0 for 1024 cycles -> timeout_err pulse on stall count 1023, GAP, then IDLE.
REQ-038 Directed test, enable drop: enable=0 mid-packet on FIFO 2 -> packet completes and bus_sel stays 0 afterwards despite requests.
REQ-039 Directed test, reset mid-packet: rst asserted on beat 2 of FIFO 7 -> bus_sel=0 the next cycle, no pkt_done, and the next grant is FIFO 0.
